// File: rtl/cpuc_reg_dump.sv
// -----------------------------------------------------------------------------
// cpuc_package / cpuc_reg_dump
//
// Purpose:
//   Debug/trace reader for the CPUC register-output bundle. On request it takes
//   an atomic snapshot of all general registers plus the PC into a shadow
//   register. It then streams that snapshot one word at a time over a
//   valid/ready interface. The CPU datapath is never stalled: the live bundle
//   is sampled once and is not looked at again until the next request.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   reg_outputs_in in   live register + PC bundle (t_reg_outputs)
//   snap_req       in   snapshot request, level-sampled every cycle
//   snap_busy      out  snapshot in progress (streaming or completing)
//   snap_done      out  one-cycle pulse after the last word is transferred
//   snap_drop      out  one-cycle pulse per cycle a request arrives while busy
//   out_valid      out  out_data / out_idx / out_last are valid
//   out_ready      in   downstream accepts the current word
//   out_data       out  snapshot word
//   out_idx        out  word index: 0..NUM_OF_REGS-1 registers, NUM_OF_REGS PC
//   out_last       out  high with the final word (the PC)
//   snap_cnt       out  number of completed snapshots, wraps
// -----------------------------------------------------------------------------

package cpuc_package;

    localparam int DATA_WIDTH  = 32;
    localparam int NUM_OF_REGS = 8;
    localparam int NUM_OF_PC   = 1;

    typedef logic [DATA_WIDTH-1:0] t_word;

    // PC sits above the register file. Flattened, word i of the bundle is
    // register i for i < NUM_OF_REGS, and the PC is the topmost word. The
    // streaming order (register 0 first, PC last) falls straight out of this
    // layout.
    typedef struct packed {
        t_word                   pc;
        t_word [NUM_OF_REGS-1:0] regs;
    } t_reg_outputs;

endpackage


module cpuc_reg_dump #(
    parameter int DATA_WIDTH = cpuc_package::DATA_WIDTH,
    parameter int NUM_WORDS  = cpuc_package::NUM_OF_REGS + cpuc_package::NUM_OF_PC,
    parameter int IDX_WIDTH  = $clog2(NUM_WORDS),
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  cpuc_package::t_reg_outputs  reg_outputs_in,
    input  logic                        snap_req,
    output logic                        snap_busy,
    output logic                        snap_done,
    output logic                        snap_drop,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [IDX_WIDTH-1:0]        out_idx,
    output logic                        out_last,
    output logic [CNT_WIDTH-1:0]        snap_cnt
);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SEND = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]                           state;
    logic [1:0]                           state_nxt;
    logic [IDX_WIDTH-1:0]                 idx;
    logic [IDX_WIDTH-1:0]                 idx_nxt;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] shadow;

    logic capture;   // IDLE edge that accepts a request
    logic xfer;      // a word is handed to the downstream this cycle
    logic complete;  // DONE cycle: the snapshot is counted at its edge

    assign capture  = (state == ST_IDLE) && snap_req;
    assign xfer     = (state == ST_SEND) && out_ready;
    assign complete = (state == ST_DONE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default on entry, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (snap_req) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx + IDX_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments throughout, so every register here sees
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            // NOTE: the shadow is a bank of flops, not a RAM macro, so it
            // can be cleared here. A stale snapshot is never observable
            // anyway, because out_data is gated by out_valid.
            shadow   <= '0;
            snap_cnt <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // The only write to the shadow: the whole bundle is taken on the
            // single accepting edge. This is what makes the dump atomic.
            if (capture) begin
                shadow <= reg_outputs_in;
            end
            if (complete) begin
                snap_cnt <= snap_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Status and stream outputs are forced low while rst is asserted, so a
    // reset takes effect on the interface without waiting for the edge. The
    // data path is zeroed outside SEND so idle output lines are quiet.
    logic in_send;
    assign in_send = (state == ST_SEND) && !rst;

    assign out_valid = in_send;
    assign out_data  = in_send ? shadow[idx] : '0;
    assign out_idx   = in_send ? idx : '0;
    assign out_last  = in_send && (idx == LAST_IDX);

    assign snap_busy = (state != ST_IDLE) && !rst;
    assign snap_done = complete && !rst;
    assign snap_drop = snap_busy && snap_req;

    // -------------------------------------------------------------------------
    // Interface invariants
    // -------------------------------------------------------------------------
    // A word that is offered but not taken must be re-offered unchanged.
    a_hold_stable : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_idx))
    );

    // The word index never runs past the PC slot.
    a_idx_range : assert property (
        @(posedge clk) disable iff (rst)
        (state == ST_SEND) |-> (idx <= LAST_IDX)
    );

endmodule

// File: tb/tb_cpuc_reg_dump.sv
// -----------------------------------------------------------------------------
// tb_cpuc_reg_dump
//
// Self-checking bench for cpuc_reg_dump. A queue-based reference model tracks
// the words the block still owes the downstream. The bench combines a
// test-1 vector table, directed corner-case sequences and a randomized phase.
// -----------------------------------------------------------------------------
module tb_cpuc_reg_dump;

    import cpuc_package::*;

    localparam int DW = 32;
    localparam int NW = 9;
    localparam int IW = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    t_reg_outputs  reg_outputs_in;
    logic          snap_req;
    logic          snap_busy;
    logic          snap_done;
    logic          snap_drop;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic [CW-1:0] snap_cnt;

    cpuc_reg_dump dut (
        .clk            (clk),
        .rst            (rst),
        .reg_outputs_in (reg_outputs_in),
        .snap_req       (snap_req),
        .snap_busy      (snap_busy),
        .snap_done      (snap_done),
        .snap_drop      (snap_drop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_idx        (out_idx),
        .out_last       (out_last),
        .snap_cnt       (snap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: a queue of words still owed, plus a pending "done" beat
    // and the completed-snapshot count.
    // -------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
    } word_t;

    word_t mq[$];
    bit    m_done  = 0;
    int    m_cnt   = 0;
    bit    model_on = 0;

    task automatic model_check();
        logic ev;
        logic busy_m;
        ev     = (mq.size() > 0) && !rst;
        busy_m = ((mq.size() > 0) || m_done) && !rst;
        check("m_valid", out_valid, ev);
        check("m_data",  out_data,  ev ? mq[0].data : '0);
        check("m_idx",   out_idx,   ev ? mq[0].idx  : '0);
        check("m_last",  out_last,  ev && (mq[0].idx == NW - 1));
        check("m_done",  snap_done, m_done && !rst);
        check("m_busy",  snap_busy, busy_m);
        check("m_drop",  snap_drop, busy_m && snap_req);
        check("m_cnt",   snap_cnt,  m_cnt);
    endtask

    // Applied right after the active edge, using the inputs that edge saw.
    task automatic model_update();
        if (rst) begin
            mq.delete();
            m_done = 0;
            m_cnt  = 0;
        end else if (m_done) begin
            m_done = 0;
            m_cnt  = (m_cnt + 1) % 256;
        end else if (mq.size() > 0) begin
            if (out_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1;
            end
        end else if (snap_req) begin
            for (int i = 0; i < NUM_OF_REGS; i++)
                mq.push_back('{data: reg_outputs_in.regs[i], idx: IW'(i)});
            mq.push_back('{data: reg_outputs_in.pc, idx: IW'(NUM_OF_REGS)});
        end
    endtask

    // -------------------------------------------------------------------------
    // Cycle driver and observation
    // -------------------------------------------------------------------------
    logic [DW-1:0] got[$];
    int            n_done = 0;
    int            n_drop = 0;
    int            done_cycles[$];
    logic [CW-1:0] last_done_cnt;

    task automatic drive_sample(input logic req, input logic rdy, input logic r);
        snap_req  = req;
        out_ready = rdy;
        rst       = r;
        #1;
        if (model_on) model_check();
        if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
        if (snap_done === 1'b1) begin
            n_done++;
            done_cycles.push_back(cyc);
            last_done_cnt = snap_cnt;
        end
        if (snap_drop === 1'b1) n_drop++;
    endtask

    task automatic advance();
        @(posedge clk);
        if (model_on) model_update();
        cyc++;
        #1;
    endtask

    task automatic cycle(input logic req, input logic rdy, input logic r);
        drive_sample(req, rdy, r);
        advance();
    endtask

    task automatic set_test1_regs();
        for (int i = 0; i < NUM_OF_REGS; i++) reg_outputs_in.regs[i] = 32'h1000_0000 + i;
        reg_outputs_in.pc = 32'h0000_0040;
    endtask

    // Stream until snap_done is seen, within a cycle budget.
    task automatic run_to_done(input string name, input int budget, input bit bp);
        int c;
        c = 0;
        while (n_done == 0 && c < budget) begin
            // Backpressure pattern 1,0,0,1 repeating.
            cycle(1'b0, bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1, 1'b0);
            c++;
        end
        check({name, "_done_seen"}, n_done, 1);
    endtask

    task automatic check_words(input string name);
        check({name, "_nwords"}, got.size(), NW);
        for (int i = 0; i < NW && i < got.size(); i++)
            check({name, "_word"}, got[i], (i < NUM_OF_REGS) ? 32'h1000_0000 + i : 32'h40);
    endtask

    // -------------------------------------------------------------------------
    // Test-1 vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic          req;
        logic          rdy;
        logic          e_valid;
        logic [IW-1:0] e_idx;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic          e_done;
        logic          e_busy;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        for (int k = 0; k < 12; k++) begin
            tbl[k] = '{req: 1'b0, rdy: 1'b1, e_valid: 1'b0, e_idx: '0, e_data: '0,
                       e_last: 1'b0, e_done: 1'b0, e_busy: 1'b0, e_cnt: '0};
            if (k == 0) tbl[k].req = 1'b1;
            if (k >= 1 && k <= 9) begin
                tbl[k].e_valid = 1'b1;
                tbl[k].e_idx   = IW'(k - 1);
                tbl[k].e_data  = (k - 1 < 8) ? 32'h1000_0000 + (k - 1) : 32'h0000_0040;
                tbl[k].e_last  = (k == 9);
                tbl[k].e_busy  = 1'b1;
            end
            if (k == 10) begin
                tbl[k].e_done = 1'b1;
                tbl[k].e_busy = 1'b1;
            end
            if (k == 11) tbl[k].e_cnt = 8'd1;
        end

        snap_req  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        set_test1_regs();

        // Reset: the first edge defines DUT state, then the model joins.
        cycle(1'b0, 1'b0, 1'b1);
        model_on = 1;
        cycle(1'b0, 1'b0, 1'b1);

        drive_sample(1'b0, 1'b0, 1'b0);
        check("rst_valid", out_valid, 0);
        check("rst_busy",  snap_busy, 0);
        check("rst_done",  snap_done, 0);
        check("rst_drop",  snap_drop, 0);
        check("rst_last",  out_last,  0);
        check("rst_data",  out_data,  0);
        check("rst_idx",   out_idx,   0);
        check("rst_cnt",   snap_cnt,  0);
        advance();

        // ---- Test 1: basic dump, table driven ----
        for (int k = 0; k < 12; k++) begin
            drive_sample(tbl[k].req, tbl[k].rdy, 1'b0);
            check("t1_valid", out_valid, tbl[k].e_valid);
            check("t1_idx",   out_idx,   tbl[k].e_idx);
            check("t1_data",  out_data,  tbl[k].e_data);
            check("t1_last",  out_last,  tbl[k].e_last);
            check("t1_done",  snap_done, tbl[k].e_done);
            check("t1_busy",  snap_busy, tbl[k].e_busy);
            check("t1_cnt",   snap_cnt,  tbl[k].e_cnt);
            advance();
        end

        // ---- Test 2: backpressure ----
        got.delete(); n_done = 0;
        cycle(1'b1, 1'b1, 1'b0);
        run_to_done("t2", 60, 1'b1);
        check_words("t2");
        check("t2_cnt", snap_cnt, 2);

        // ---- Test 3: atomicity ----
        got.delete(); n_done = 0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NUM_OF_REGS; i++) reg_outputs_in.regs[i] = 32'hDEAD_BEEF;
        reg_outputs_in.pc = 32'hDEAD_BEEF;
        run_to_done("t3", 30, 1'b0);
        check_words("t3");
        check("t3_cnt", snap_cnt, 3);
        set_test1_regs();

        // ---- Test 4: requests while busy (idx 3 and DONE) ----
        got.delete(); n_done = 0; n_drop = 0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 11; k++) cycle((k == 4) || (k == 10), 1'b1, 1'b0);
        check("t4_drops", n_drop, 2);
        check("t4_dones", n_done, 1);
        check_words("t4");
        check("t4_cnt", snap_cnt, 4);

        // ---- Test 5: reset at idx 5 ----
        got.delete(); n_done = 0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b1, 1'b0);
        check("t5_idx_at_rst", out_idx, 5);
        cycle(1'b0, 1'b0, 1'b1);
        drive_sample(1'b0, 1'b1, 1'b0);
        check("t5_valid", out_valid, 0);
        check("t5_busy",  snap_busy, 0);
        check("t5_cnt",   snap_cnt,  0);
        check("t5_no_done", n_done, 0);
        advance();
        got.delete();
        cycle(1'b1, 1'b1, 1'b0);
        run_to_done("t5b", 30, 1'b0);
        check_words("t5b");
        check("t5b_cnt", snap_cnt, 1);

        // ---- Test 6: back-to-back, 256 snapshots, counter wrap ----
        cycle(1'b0, 1'b1, 1'b1);
        n_done = 0; done_cycles.delete();
        for (int c = 0; c < 256 * 11 + 30 && n_done < 256; c++) cycle(1'b1, 1'b1, 1'b0);
        check("t6_dones", n_done, 256);
        begin
            int bad;
            bad = 0;
            for (int i = 1; i < done_cycles.size(); i++)
                if (done_cycles[i] - done_cycles[i-1] != 11) bad++;
            check("t6_gap_errors", bad, 0);
        end
        check("t6_cnt_before_wrap", last_done_cnt, 255);
        check("t6_cnt_wrapped", snap_cnt, 0);
        for (int c = 0; c < 12; c++) cycle(1'b0, 1'b1, 1'b0);

        // ---- Randomized phase against the model ----
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_OF_REGS; i++) reg_outputs_in.regs[i] = $urandom();
            reg_outputs_in.pc = $urandom();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        for (int c = 0; c < 40; c++) cycle(1'b0, 1'b1, 1'b0);
        check("end_idle_busy", snap_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpuc_reg_dump.md
Name: cpuc_reg_dump

Overview:
Reader/consumer side of the CPUC register-output bundle (t_reg_outputs from cpuc_package).
- On request, takes an atomic snapshot of all general registers plus the PC.
- Streams the snapshot out one DATA_WIDTH word per transfer over a valid/ready interface.
- Used by debug/trace logic to read CPU state without stalling the datapath.

Parameters:
DATA_WIDTH, cpuc_package::DATA_WIDTH (32), width of each streamed word
NUM_WORDS, cpuc_package::NUM_OF_REGS + cpuc_package::NUM_OF_PC (9), words per snapshot
IDX_WIDTH, $clog2(NUM_WORDS) (4), width of word index
CNT_WIDTH, 8, width of completed-snapshot counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
reg_outputs_in  input  t_reg_outputs (NUM_WORDS*DATA_WIDTH = 288)  live register + PC bundle
snap_req  input  1  snapshot request (level-sampled each cycle)
snap_busy  output  1  snapshot in progress
snap_done  output  1  one-cycle pulse after last word transferred
snap_drop  output  1  one-cycle pulse when snap_req arrives while busy
out_valid  output  1  out_data/out_idx/out_last valid
out_ready  input  1  downstream accepts word
out_data  output  DATA_WIDTH  snapshot word
out_idx  output  IDX_WIDTH  word index; 0..NUM_OF_REGS-1 = registers, NUM_OF_REGS = PC
out_last  output  1  high with the word at idx NUM_WORDS-1
snap_cnt  output  CNT_WIDTH  number of completed snapshots, wraps

Behaviour:
- Clock and reset: one clock clk; rst is synchronous, active-high.
- Reset values: state IDLE; idx 0; shadow 0; snap_cnt 0.
- Outputs during/after reset: snap_busy, snap_done, snap_drop, out_valid, out_last, out_data, out_idx all 0.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - If snap_req=1, capture the whole reg_outputs_in into the shadow register in that same edge, set idx=0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - out_valid=1; out_data=shadow[idx]; out_idx=idx; out_last=(idx==NUM_WORDS-1).
  - Transfer occurs when out_valid && out_ready.
  - On a transfer with idx<NUM_WORDS-1: idx++.
  - On a transfer with idx==NUM_WORDS-1: go to DONE.
  - With out_ready=0: hold all out_* stable, no advance.
- DONE:
  - snap_done=1 for exactly one cycle; snap_cnt++ (wraps 2^CNT_WIDTH-1 -> 0).
  - Return to IDLE.
- snap_busy = (state != IDLE).
- Latency: snap_req sampled at edge N -> word 0 valid in cycle N+1.
- With out_ready held at 1:
  - words occupy cycles N+1..N+NUM_WORDS;
  - snap_done in cycle N+NUM_WORDS+1;
  - the next request is accepted at the following edge.
- Atomicity:
  - out_data comes only from the shadow register.
  - Changes on reg_outputs_in after the capture edge never appear in the current stream.
- Request while busy (SEND or DONE): ignored; snap_drop pulses 1 cycle per cycle snap_req is high; the current stream is unaffected.
- snap_req held high continuously: a new snapshot starts each time the FSM reaches IDLE; one IDLE cycle separates snapshots.
- Reset mid-stream:
  - aborts immediately; next cycle out_valid=0, state IDLE;
  - no snap_done; snap_cnt cleared.
- out_valid never drops without a transfer, except on rst.
- Word order is fixed: register 0 first, PC last.

Test Plan:
1. Basic dump: regs r[i]=32'h1000_0000+i, PC=32'h0000_0040; snap_req 1 cycle, out_ready=1 -> 9 consecutive words, idx 0..8, data 10000000..10000007 then 00000040; out_last only at idx 8; snap_done 1 cycle after; snap_cnt=1.
2. Backpressure: out_ready toggles 1,0,0,1,... -> each word held stable while ready=0; no word skipped or duplicated; same 9-word sequence as test 1.
3. Atomicity: change every reg_outputs_in value to 32'hDEAD_BEEF one cycle after capture -> stream still returns the test-1 values.
4. Busy request: pulse snap_req at idx 3 and during DONE -> snap_drop pulses in exactly those 2 cycles; only 1 snap_done; snap_cnt increments by 1.
5. Reset mid-operation: assert rst at idx 5 -> next cycle out_valid=0, busy=0, snap_cnt=0; no snap_done; new snap_req then yields a full 9-word dump from idx 0.
6. Back-to-back and wrap: hold snap_req=1 with out_ready=1 for 256 snapshots -> one idle cycle between streams; snap_cnt wraps 255 -> 0.
